dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one request at a time, waits a
// fixed latency, performs the access and emits a one-cycle response strobe.
module dmem_responder #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        busy,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [DEPTH_LOG2+1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;
    logic                  access;
    logic                  misaligned;
    logic [DEPTH_LOG2-1:0] idx;

    logic [31:0] mem_q [0:(2**DEPTH_LOG2)-1];

    // Upper address bits only alias; they never reach the array.
    logic unused_addr;
    assign unused_addr = ^req_addr[31:DEPTH_LOG2+2];

    assign idx        = addr_q[DEPTH_LOG2+1:2];
    assign misaligned = (addr_q[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        access  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr[DEPTH_LOG2+1:0];
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    access  = 1'b1;
                    err_d   = misaligned;
                    rdata_d = (!misaligned && !we_q) ? mem_q[idx] : 32'd0;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Array is deliberately not reset; a reset-aborted write never sees access=1.
    always_ff @(posedge clk) begin
        if (access && we_q && !misaligned) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) mem_q[idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

    assign busy       = (state_q != IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: stimulus pushes expected responses,
// a negedge monitor pops and compares on every resp_valid strobe.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic [3:0]  req_be = 4'd0;
    logic        busy, resp_valid, resp_err;
    logic [31:0] resp_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        bit          ne;     // pass when rdata differs from the value given
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;
    int   pulses = 0;
    int   pushed = 0;

    dmem_responder #(.DEPTH_LOG2(8), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .busy(busy), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one pop per response strobe.
    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                exp_t e;
                pulses++;
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_resp: got rdata %h err %b with empty queue", resp_rdata, resp_err);
                end else begin
                    e = q.pop_front();
                    if (resp_err !== e.err || (e.ne ? (resp_rdata === e.rdata) : (resp_rdata !== e.rdata))) begin
                        fails++;
                        $display("FAIL resp_data: got rdata %h err %b expected %s%h err %b",
                                 resp_rdata, resp_err, e.ne ? "not " : "", e.rdata, e.err);
                    end
                end
            end
        end
    end

    task automatic push(input logic err, input logic [31:0] rdata, input bit ne);
        exp_t e;
        e.err = err; e.rdata = rdata; e.ne = ne;
        q.push_back(e);
        pushed++;
    endtask

    // Issue one request and check handshake timing around it.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, input logic eerr, input logic [31:0] erd, input bit ne);
        int edges;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        push(eerr, erd, ne);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        edges = 0;
        while (!resp_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk("resp_latency", edges, LAT);
        @(posedge clk); #1;
        chk("resp_one_cycle", {30'd0, busy, resp_valid}, 32'd0);
    endtask

    initial begin
        int waitc;
        #12;
        chk("reset_outputs", {resp_rdata[29:0], resp_err, busy}, 32'd0);
        chk("reset_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clk); rst = 1'b0;

        do_req(1, 32'h10,  32'hDEADBEEF, 4'b1111, 0, 32'h0, 0);
        do_req(0, 32'h10,  32'h0,        4'b1111, 0, 32'hDEADBEEF, 0);
        do_req(1, 32'h10,  32'h000000AA, 4'b0001, 0, 32'h0, 0);
        do_req(0, 32'h10,  32'h0,        4'b1111, 0, 32'hDEADBEAA, 0);
        do_req(1, 32'h12,  32'h11111111, 4'b1111, 1, 32'h0, 0);
        do_req(0, 32'h10,  32'h0,        4'b1111, 0, 32'hDEADBEAA, 0);
        do_req(1, 32'h410, 32'h12345678, 4'b1111, 0, 32'h0, 0);
        do_req(0, 32'h10,  32'h0,        4'b1111, 0, 32'h12345678, 0);
        do_req(1, 32'h10,  32'hFFFFFFFF, 4'b0000, 0, 32'h0, 0);
        do_req(0, 32'h10,  32'h0,        4'b0000, 0, 32'h12345678, 0);
        do_req(0, 32'h11,  32'h0,        4'b1111, 1, 32'h0, 0);

        // Busy drop: second request lands one cycle after acceptance.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = 4'hF;
        push(0, 32'h12345678, 0);
        @(negedge clk);
        req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        waitc = 0;
        while (busy && waitc < 20) begin @(negedge clk); waitc++; end
        chk("busy_drop_idle", {31'd0, busy}, 32'd0);
        repeat (4) @(negedge clk);

        // Reset abort while waiting on a write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hCAFEF00D; req_be = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("abort_in_wait", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_outputs", {30'd0, busy, resp_valid}, 32'd0);
        chk("abort_rdata", resp_rdata, 32'd0);
        chk("abort_err", {31'd0, resp_err}, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        do_req(0, 32'h30, 32'h0, 4'hF, 0, 32'hCAFEF00D, 1);
        do_req(1, 32'h30, 32'h0, 4'hF, 0, 32'h0, 0);
        do_req(0, 32'h30, 32'h0, 4'hF, 0, 32'h0, 0);

        repeat (3) @(negedge clk);
        chk("pulse_count", pulses, pushed);
        chk("queue_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
        $fatal(1, "timeout");
    end

endmodule
